// File: rtl/mulu_pkg.sv
// Shared types and sizing helpers for the m7q7 multiplier sequencer.
// MULU_SEQ_Q7_ROUND_EN selects the single rounded Q7 output byte instead of raw product bytes.
package mulu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StWait,
        StSend
    } state_e;

    localparam int unsigned DefWidth = 8;

    function automatic int unsigned beats(input int unsigned w);
        return w / 2;
    endfunction

    function automatic int unsigned nbytes(input int unsigned w);
`ifdef MULU_SEQ_Q7_ROUND_EN
        return (w > 0) ? 1 : 1;
`else
        return (2 * w) / 8;
`endif
    endfunction

    localparam int unsigned Nb     = beats(DefWidth);
    localparam int unsigned NBytes = nbytes(DefWidth);

endpackage

// File: rtl/mulu_m7q7_sequencer_if.sv
// Beat input, core operand/result and byte output handshakes of the sequencer.
interface mulu_m7q7_sequencer_if #(
    parameter int unsigned WIDTH = mulu_pkg::DefWidth
);
    logic                 in_valid;
    logic [3:0]           in_nibble;
    logic                 in_clear;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 op_valid;
    logic                 op_ready;
    logic [2*WIDTH-1:0]   res_in;
    logic                 res_valid;
    logic [7:0]           out_byte;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 overrun;

    modport slave (
        input  in_valid, in_nibble, in_clear, op_ready, res_in, res_valid, out_ready,
        output op_a, op_b, op_valid, out_byte, out_valid, busy, overrun
    );

    modport master (
        output in_valid, in_nibble, in_clear, op_ready, res_in, res_valid, out_ready,
        input  op_a, op_b, op_valid, out_byte, out_valid, busy, overrun
    );
endinterface

// File: rtl/mulu_nibble_deser.sv
// Nibble deserialiser: shifts beats in from the top so the first beat lands in op_a[3:0].
module mulu_nibble_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [3:0]       nibble,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b
);
    logic [2*WIDTH-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (clear) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= {nibble, sr_q[2*WIDTH-1:4]};
        end
    end

    assign op_a = sr_q[WIDTH-1:0];
    assign op_b = sr_q[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/mulu_m7q7_sequencer.sv
// Beat-in / byte-out sequencer around the m7q7 multiplier core.
// MULU_SEQ_Q7_ROUND_EN: emit one saturated round-half-up Q7 byte instead of raw product bytes.
module mulu_m7q7_sequencer
    import mulu_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input logic clk,
    input logic rst_n,
    mulu_m7q7_sequencer_if.slave bus
);
    localparam int unsigned BeatCnt = beats(WIDTH);
    localparam int unsigned ByteCnt = nbytes(WIDTH);
    localparam int unsigned CW      = $clog2(BeatCnt);
    localparam int unsigned IW      = (ByteCnt > 1) ? $clog2(ByteCnt) : 1;

    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of 8");
    end
`ifdef MULU_SEQ_Q7_ROUND_EN
    if (WIDTH != 8) begin : g_bad_round
        $error("Q7 rounding mode requires WIDTH=8");
    end
`endif

    state_e             state_q;
    logic [CW-1:0]      beat_q;
    logic [IW-1:0]      idx_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               op_valid_q;
    logic               out_valid_q;
    logic               overrun_q;
    logic               beat_ok;

    assign beat_ok = bus.in_valid && (state_q == StIdle || state_q == StLoad);

    mulu_nibble_deser #(.WIDTH(WIDTH)) u_deser (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (beat_ok && !bus.in_clear),
        .clear  (bus.in_clear),
        .nibble (bus.in_nibble),
        .op_a   (bus.op_a),
        .op_b   (bus.op_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            idx_q       <= '0;
            prod_q      <= '0;
            op_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (bus.in_clear) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            idx_q       <= '0;
            prod_q      <= '0;
            op_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (bus.in_valid && !beat_ok) overrun_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        beat_q  <= CW'(1);
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (bus.in_valid) begin
                        if (beat_q == CW'(BeatCnt - 1)) begin
                            beat_q     <= '0;
                            op_valid_q <= 1'b1;
                            state_q    <= StIssue;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (bus.res_valid) begin
                        prod_q      <= bus.res_in;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= StSend;
                    end
                end
                StSend: begin
                    if (bus.out_ready) begin
                        if (idx_q == IW'(ByteCnt - 1)) begin
                            out_valid_q <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MULU_SEQ_Q7_ROUND_EN
    logic [8:0] rnd;
    // Carry out of the rounding add saturates just like a set sign-extension bit.
    always_comb begin
        rnd          = {1'b0, prod_q[2*WIDTH-2:WIDTH-1]} + 9'(prod_q[WIDTH-2]);
        bus.out_byte = (prod_q[2*WIDTH-1] || rnd[8]) ? 8'hFF : rnd[7:0];
    end
`else
    always_comb begin
        bus.out_byte = prod_q[idx_q*8 +: 8];
    end
`endif

    assign bus.op_valid  = op_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_mulu_m7q7_sequencer.sv
// Self-checking bench: vector table, hand-built corner sequences and randomized jobs.
// Honours MULU_SEQ_Q7_ROUND_EN for the expected output byte stream.
module tb_mulu_m7q7_sequencer;
    localparam int unsigned W  = 8;
    localparam int unsigned NB = W / 2;
`ifdef MULU_SEQ_Q7_ROUND_EN
    localparam int unsigned NBY = 1;
`else
    localparam int unsigned NBY = 2 * W / 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    mulu_m7q7_sequencer_if #(.WIDTH(W)) bus ();

    mulu_m7q7_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int unsigned op_dly;
        int unsigned out_dly;
        logic [15:0] exp_prod;
        logic [7:0]  exp_rnd;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Q7 round-half-up of an unsigned 16-bit product, saturating at 0xFF.
    function automatic logic [7:0] ref_round(input logic [15:0] p);
        int unsigned r;
        r = (int'(p) + 64) / 128;
        if (p >= 16'h8000 || r > 255) return 8'hFF;
        return r[7:0];
    endfunction

    task automatic send_beats(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ops;
        ops = {b, a};
        for (int i = 0; i < int'(NB); i++) begin
            bus.in_valid  = 1'b1;
            bus.in_nibble = ops[4*i +: 4];
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_job(input logic [7:0] a, input logic [7:0] b, input int unsigned op_dly,
                          input int unsigned res_dly, input int unsigned out_dly,
                          input bit poke, input logic [15:0] exp_prod,
                          input logic [7:0] exp_rnd);
        logic [15:0] core_p;
        logic [7:0]  exp_b;
        core_p = 16'(a) * 16'(b);
        send_beats(a, b);
        chk("op_valid", 32'(bus.op_valid), 32'd1);
        chk("op_ab", {bus.op_b, bus.op_a}, {b, a});
        for (int k = 0; k < int'(op_dly); k++) begin
            step();
            chk("op_hold", {bus.op_valid, bus.op_b, bus.op_a}, {1'b1, b, a});
        end
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        chk("op_drop", 32'(bus.op_valid), 32'd0);
        if (poke) begin
            bus.in_valid  = 1'b1;
            bus.in_nibble = 4'h9;
            step();
            bus.in_valid = 1'b0;
            chk("overrun_set", 32'(bus.overrun), 32'd1);
        end
        for (int k = 0; k < int'(res_dly); k++) step();
        bus.res_in    = core_p;
        bus.res_valid = 1'b1;
        step();
        bus.res_valid = 1'b0;
        for (int i = 0; i < int'(NBY); i++) begin
`ifdef MULU_SEQ_Q7_ROUND_EN
            exp_b = exp_rnd;
`else
            exp_b = exp_prod[8*i +: 8];
`endif
            chk("out_byte", {bus.out_valid, bus.out_byte}, {1'b1, exp_b});
            for (int k = 0; k < int'(out_dly); k++) begin
                // A stray result pulse outside WAIT must be ignored.
                bus.res_valid = (k == 0);
                bus.res_in    = ~core_p;
                step();
                bus.res_valid = 1'b0;
                chk("out_hold", {bus.out_valid, bus.out_byte}, {1'b1, exp_b});
            end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
        chk("end_idle", {bus.busy, bus.out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  ra, rb;
        logic [15:0] rp;

        vecs[0] = '{8'h80, 8'hC0, 0, 0, 16'h6000, 8'hC0};
        vecs[1] = '{8'hFF, 8'hFF, 0, 1, 16'hFE01, 8'hFF};
        vecs[2] = '{8'h00, 8'h37, 1, 0, 16'h0000, 8'h00};
        vecs[3] = '{8'h12, 8'h34, 0, 0, 16'h03A8, 8'h07};
        vecs[4] = '{8'h01, 8'h40, 2, 1, 16'h0040, 8'h01};
        vecs[5] = '{8'hB5, 8'h7F, 0, 2, 16'h59CB, 8'hB4};
        vecs[6] = '{8'h92, 8'hE0, 1, 0, 16'h7FC0, 8'hFF};
        vecs[7] = '{8'h80, 8'hC0, 5, 3, 16'h6000, 8'hC0};

        bus.in_valid  = 1'b0;
        bus.in_nibble = 4'h0;
        bus.in_clear  = 1'b0;
        bus.op_ready  = 1'b0;
        bus.res_in    = '0;
        bus.res_valid = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        chk("reset_outs", {bus.op_valid, bus.out_valid, bus.busy, bus.overrun, bus.out_byte},
            32'd0);
        chk("reset_ops", {bus.op_b, bus.op_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_job(vecs[i].a, vecs[i].b, vecs[i].op_dly, 0, vecs[i].out_dly, 1'b0,
                   vecs[i].exp_prod, vecs[i].exp_rnd);
        end

        // Beat during WAIT: sticky overrun, result intact, cleared by in_clear.
        do_job(8'h12, 8'h34, 0, 2, 0, 1'b1, 16'h03A8, 8'h07);
        chk("overrun_sticky", 32'(bus.overrun), 32'd1);
        bus.in_clear = 1'b1;
        step();
        bus.in_clear = 1'b0;
        chk("overrun_clr", {bus.overrun, bus.busy}, 32'd0);

        // Clear coinciding with the third beat discards the partial job.
        bus.in_valid  = 1'b1;
        bus.in_nibble = 4'h7;
        step();
        step();
        bus.in_clear = 1'b1;
        step();
        bus.in_clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_beat", {bus.busy, bus.op_valid, bus.op_b, bus.op_a}, 32'd0);
        rp = 16'h5A * 16'h3C;
        do_job(8'h5A, 8'h3C, 0, 0, 0, 1'b0, rp, ref_round(rp));

        // Reset in the middle of SEND.
        send_beats(8'hB5, 8'h7F);
        bus.op_ready = 1'b1;
        step();
        bus.op_ready  = 1'b0;
        bus.res_in    = 16'h59CB;
        bus.res_valid = 1'b1;
        step();
        bus.res_valid = 1'b0;
        if (NBY > 1) begin
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
        chk("send_mid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_outs", {bus.op_valid, bus.out_valid, bus.busy, bus.overrun, bus.out_byte},
            32'd0);
        chk("rst_ops", {bus.op_b, bus.op_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_job(8'h92, 8'hE0, 0, 0, 0, 1'b0, 16'h7FC0, 8'hFF);

        // Randomized back-to-back jobs against the arithmetic model.
        for (int j = 0; j < 30; j++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = 16'(ra) * 16'(rb);
            do_job(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'b0, rp, ref_round(rp));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mulu_m7q7_sequencer.md
# mulu_m7q7_sequencer

Sequential front/back end for the unsigned m7q7 multiplier core. Assembles two WIDTH-bit operands from 4-bit beats on the narrow pin bus and hands them to the core over a valid/ready handshake. It then captures the 2·WIDTH-bit product and streams it out one byte at a time under a valid/ready handshake. It sits between the pin-level `io_in`/`io_out` mapping in the tile top and the multiplier core.

## Interface
- WIDTH, 8, operand width in bits; must be a multiple of 8.
- clk  in  1  clock, rising edge; sourced from io_in[0].
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  nibble strobe; one beat is accepted on each rising edge where it is high.
- in_nibble  in  4  beat data.
- in_clear  in  1  synchronous abort.
- op_a  out  WIDTH  multiplicand to the core.
- op_b  out  WIDTH  multiplier to the core.
- op_valid  out  1  operands valid.
- op_ready  in  1  core accepts operands.
- res_in  in  2·WIDTH  product from the core.
- res_valid  in  1  product valid; single-cycle pulse.
- out_byte  out  8  result byte.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  consumer accepts the byte.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky flag: a beat arrived while the block could not accept it.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, SEND; the next-state logic is fully registered.
- Beat count: NB = WIDTH/2 beats per job (4 at WIDTH=8). A beat counter runs 0..NB-1.
- Beat order: op_a nibbles first, least significant nibble first, then op_b nibbles in the same order.
- IDLE → LOAD on the first accepted beat. LOAD → ISSUE on the edge that captures beat NB-1.
- ISSUE drives op_valid=1 with op_a/op_b stable. The transfer occurs on the edge where op_valid && op_ready, then the FSM goes to WAIT.
- WAIT captures res_in on the edge where res_valid=1, then goes to SEND. res_valid in any other state is ignored.
- SEND emits bytes of the product, least significant byte first. Each byte holds until the edge where out_valid && out_ready. The edge that transfers the last byte returns the FSM to IDLE.
- in_valid in ISSUE, WAIT or SEND: the beat is dropped and overrun is set. overrun clears only on rst_n or in_clear.
- in_clear from any state: on the next edge the FSM goes to IDLE, the beat counter is zeroed, op_valid=0, out_valid=0, overrun=0.
- in_clear has priority over every simultaneous event (in_valid, op_ready, res_valid, out_ready).
- Async reset values: all outputs 0, FSM in IDLE, beat counter 0.
- Reset asserted mid-job aborts the job immediately; no partial output is produced.

## Timing
- The edge that captures the last beat is edge E. op_valid is high in the cycle after E.
- Minimum latency from last beat to first out_valid is 3 edges (ISSUE → WAIT → SEND), with op_ready and res_valid arriving as early as possible.
- op_valid, op_a and op_b stay constant until the transfer edge. out_byte and out_valid stay constant until their transfer edge.
- Back-to-back: the first beat of the next job is accepted on the edge after the last byte transfers.

## Configuration
- MULU_SEQ_Q7_ROUND_EN, when defined:
  - SEND emits a single byte: product[2W-2:W-1] + product[W-2], i.e. round-half-up to Q7.
  - The byte saturates to 0xFF if product[2W-1]=1 or if the rounding addition carries out of 8 bits.
  - This mode requires WIDTH=8; elaboration fails for any other value.
- When not defined: SEND emits 2·WIDTH/8 raw product bytes, least significant byte first.

## Structure
- Package mulu_pkg holds:
  - the state enum;
  - the default WIDTH;
  - the NB and byte-count constants, derived from WIDTH.
- Sub-module mulu_nibble_deser: a 2·WIDTH-bit shift register with a load enable and clear, split into op_a/op_b.
- The FSM, overrun flag and output byte mux live in mulu_m7q7_sequencer.

## Test plan
- Raw mode: beats 0,8,0,C (op_a=0x80, op_b=0xC0), op_ready=1, core returns 0x6000 → op_a=0x80 and op_b=0xC0 when op_valid; out bytes 0x00 then 0x60; busy falls after the second transfer.
- Round mode, same job → exactly one byte, 0xC0. Core returns 0xFE01 → byte 0xFF (saturated).
- Backpressure: op_ready held low for 5 cycles, and out_ready held low for 3 cycles per byte → outputs stay stable throughout and each byte transfers exactly once.
- in_valid pulsed during WAIT → overrun=1 and the job result is unchanged. A following in_clear → overrun=0 and the FSM returns to IDLE.
- in_clear asserted in the same cycle as the 3rd beat → beat discarded, beat counter 0. The next 4 beats form a complete new job.
- rst_n pulsed low during SEND after byte 0 → all outputs 0 immediately. The next job completes normally.
